// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
package imem_arb_pkg;

    // Arbiter ownership phases: normal fetch traffic, hand-over, loader-owned.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } arb_state_t;

    // Which requester the read data returning next cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } rsp_owner_t;

    // Denied loader cycles in RUN before the loader is forced through once.
    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/imem_port_arbiter.sv
// Shares the single imem BRAM port between the IF stage and the UART
// loader/debug port. The loader can lock the port to rewrite program memory.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ld_lock,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_locked,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state;
    rsp_owner_t       rsp_owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    assign starve_hit = (starve_cnt == STARVE_LIM);

    // Grant selection and BRAM port muxing; everything is held at zero during reset.
    always_comb begin
        if_gnt    = 1'b0;
        ld_gnt    = 1'b0;
        mem_ena   = 1'b0;
        mem_wea   = 1'b0;
        mem_addra = '0;
        mem_dina  = '0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (ld_req && starve_hit) begin
                        ld_gnt = 1'b1;
                    end else if (if_req) begin
                        if_gnt = 1'b1;
                    end else if (ld_req) begin
                        ld_gnt = 1'b1;
                    end
                end
                DRAIN: begin
                end
                LOAD: begin
                    ld_gnt = ld_req;
                end
                default: begin
                end
            endcase
        end
        mem_ena = if_gnt | ld_gnt;
        mem_wea = ld_gnt & ld_we;
        if (if_gnt) begin
            mem_addra = if_addr;
        end else if (ld_gnt) begin
            mem_addra = ld_addr;
            mem_dina  = ld_wdata;
        end
    end

    // Ownership FSM, loader starvation counter and read-response tracker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            starve_cnt <= '0;
            rsp_owner  <= OWN_NONE;
        end else begin
            if (if_gnt) begin
                rsp_owner <= OWN_IF;
            end else if (ld_gnt && !ld_we) begin
                rsp_owner <= OWN_LD;
            end else begin
                rsp_owner <= OWN_NONE;
            end

            case (state)
                RUN: begin
                    if (ld_req && !ld_gnt) begin
                        if (!starve_hit) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                    if (ld_lock) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // No grants here, so a read granted on the way in returns
                    // during this cycle and nothing is left in flight afterwards.
                    starve_cnt <= '0;
                    state      <= LOAD;
                end
                LOAD: begin
                    starve_cnt <= '0;
                    if (!ld_lock) begin
                        state <= RUN;
                    end
                end
                default: begin
                    starve_cnt <= '0;
                    state      <= RUN;
                end
            endcase
        end
    end

    assign if_rvalid = rst_n && (rsp_owner == OWN_IF);
    assign ld_rvalid = rst_n && (rsp_owner == OWN_LD);
    assign if_rdata  = mem_douta;
    assign ld_rdata  = mem_douta;
    assign ld_locked = (state == LOAD);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed, table-driven bench for imem_port_arbiter with a simple BRAM model.
module tb_imem_port_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ld_lock;
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_locked;
    logic              mem_ena;
    logic              mem_wea;
    logic [ADDR_W-1:0] mem_addra;
    logic [DATA_W-1:0] mem_dina;
    logic [DATA_W-1:0] mem_douta;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic              rst_n;
        logic              if_req;
        logic [ADDR_W-1:0] if_addr;
        logic              ld_lock;
        logic              ld_req;
        logic              ld_we;
        logic [ADDR_W-1:0] ld_addr;
        logic [DATA_W-1:0] ld_wdata;
        logic              e_if_gnt;
        logic              e_ld_gnt;
        logic              e_if_rv;
        logic              e_ld_rv;
        logic              e_locked;
        logic              e_ena;
        logic              e_wea;
        logic [ADDR_W-1:0] e_addra;
        logic [DATA_W-1:0] e_dina;
        int                e_chk;
        logic [DATA_W-1:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    imem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ld_lock   (ld_lock),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .ld_rvalid (ld_rvalid),
        .ld_rdata  (ld_rdata),
        .ld_locked (ld_locked),
        .mem_ena   (mem_ena),
        .mem_wea   (mem_wea),
        .mem_addra (mem_addra),
        .mem_dina  (mem_dina),
        .mem_douta (mem_douta)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: unwritten words return a fixed address-derived pattern.
    logic [DATA_W-1:0] mem [2**ADDR_W];
    bit                written [2**ADDR_W];

    function automatic logic [DATA_W-1:0] initVal(input logic [ADDR_W-1:0] a);
        case (a)
            11'd0:   return 32'h0000_0011;
            11'd1:   return 32'h0000_0022;
            11'd2:   return 32'h0000_0033;
            11'd3:   return 32'h0000_0044;
            default: return 32'hC000_0000 | {21'd0, a};
        endcase
    endfunction

    // Registered read, write with no read data, one access per cycle.
    always @(posedge clk) begin
        if (mem_ena) begin
            if (mem_wea) begin
                mem[mem_addra]     <= mem_dina;
                written[mem_addra] <= 1'b1;
            end else begin
                mem_douta <= written[mem_addra] ? mem[mem_addra] : initVal(mem_addra);
            end
        end
    end

    function automatic void addVec(
        input logic rs, input logic ifr, input logic [ADDR_W-1:0] ifa,
        input logic lk, input logic ldr, input logic we,
        input logic [ADDR_W-1:0] lda, input logic [DATA_W-1:0] wd,
        input logic eig, input logic elg, input logic eiv, input logic elv,
        input logic elk, input logic een, input logic ewe,
        input logic [ADDR_W-1:0] ead, input logic [DATA_W-1:0] edi,
        input int chk, input logic [DATA_W-1:0] erd);
        vec_t v;
        v.rst_n = rs;   v.if_req = ifr; v.if_addr = ifa;
        v.ld_lock = lk; v.ld_req = ldr; v.ld_we = we;
        v.ld_addr = lda; v.ld_wdata = wd;
        v.e_if_gnt = eig; v.e_ld_gnt = elg; v.e_if_rv = eiv; v.e_ld_rv = elv;
        v.e_locked = elk; v.e_ena = een; v.e_wea = ewe;
        v.e_addra = ead; v.e_dina = edi; v.e_chk = chk; v.e_rdata = erd;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n    = v.rst_n;
        if_req   = v.if_req;
        if_addr  = v.if_addr;
        ld_lock  = v.ld_lock;
        ld_req   = v.ld_req;
        ld_we    = v.ld_we;
        ld_addr  = v.ld_addr;
        ld_wdata = v.ld_wdata;
    endtask

    task automatic checkOutput(input string name, input int row,
                               input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic checkVec(input vec_t v, input int row);
        checkOutput("if_gnt",    row, 32'(if_gnt),    32'(v.e_if_gnt));
        checkOutput("ld_gnt",    row, 32'(ld_gnt),    32'(v.e_ld_gnt));
        checkOutput("if_rvalid", row, 32'(if_rvalid), 32'(v.e_if_rv));
        checkOutput("ld_rvalid", row, 32'(ld_rvalid), 32'(v.e_ld_rv));
        checkOutput("ld_locked", row, 32'(ld_locked), 32'(v.e_locked));
        checkOutput("mem_ena",   row, 32'(mem_ena),   32'(v.e_ena));
        checkOutput("mem_wea",   row, 32'(mem_wea),   32'(v.e_wea));
        checkOutput("mem_addra", row, 32'(mem_addra), 32'(v.e_addra));
        checkOutput("mem_dina",  row, mem_dina,       v.e_dina);
        if (v.e_chk == 1) checkOutput("if_rdata", row, if_rdata, v.e_rdata);
        if (v.e_chk == 2) checkOutput("ld_rdata", row, ld_rdata, v.e_rdata);
    endtask

    function automatic vec_t inVec(input logic rs, input logic ifr, input logic [ADDR_W-1:0] ifa,
                                   input logic lk, input logic ldr, input logic we,
                                   input logic [ADDR_W-1:0] lda);
        vec_t v;
        v = '{default: '0};
        v.rst_n = rs; v.if_req = ifr; v.if_addr = ifa;
        v.ld_lock = lk; v.ld_req = ldr; v.ld_we = we; v.ld_addr = lda;
        return v;
    endfunction

    // Drives the vector table, then the hand-written reset sequences.
    initial begin
        localparam logic [DATA_W-1:0] WD = 32'h1234_5678;
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ld_lock = 1'b0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;

        //      rst ifr ifa   lk ldr we lda    wd           | ig lg iv lv lk en we adr    dina          chk rdata
        addVec(0, 1, 11'h0, 0, 1, 0, 11'h20, WD,            0, 0, 0, 0, 0, 0, 0, 11'h0,  0,            0, 0);
        addVec(0, 0, 11'h0, 0, 0, 0, 11'h0,  0,             0, 0, 0, 0, 0, 0, 0, 11'h0,  0,            0, 0);
        addVec(1, 0, 11'h0, 0, 0, 0, 11'h0,  0,             0, 0, 0, 0, 0, 0, 0, 11'h0,  0,            0, 0);
        addVec(1, 1, 11'h0, 0, 0, 0, 11'h0,  0,             1, 0, 0, 0, 0, 1, 0, 11'h0,  0,            0, 0);
        addVec(1, 1, 11'h1, 0, 0, 0, 11'h0,  0,             1, 0, 1, 0, 0, 1, 0, 11'h1,  0,            1, 32'h11);
        addVec(1, 1, 11'h2, 0, 0, 0, 11'h0,  0,             1, 0, 1, 0, 0, 1, 0, 11'h2,  0,            1, 32'h22);
        addVec(1, 1, 11'h3, 0, 0, 0, 11'h0,  0,             1, 0, 1, 0, 0, 1, 0, 11'h3,  0,            1, 32'h33);
        addVec(1, 0, 11'h0, 0, 0, 0, 11'h0,  0,             0, 0, 1, 0, 0, 0, 0, 11'h0,  0,            1, 32'h44);
        addVec(1, 0, 11'h0, 0, 0, 0, 11'h0,  0,             0, 0, 0, 0, 0, 0, 0, 11'h0,  0,            0, 0);
        addVec(1, 1, 11'h4, 0, 1, 0, 11'h20, WD,            1, 0, 0, 0, 0, 1, 0, 11'h4,  0,            0, 0);
        addVec(1, 1, 11'h4, 0, 1, 0, 11'h20, WD,            1, 0, 1, 0, 0, 1, 0, 11'h4,  0,            1, 32'hC000_0004);
        addVec(1, 1, 11'h4, 0, 1, 0, 11'h20, WD,            1, 0, 1, 0, 0, 1, 0, 11'h4,  0,            1, 32'hC000_0004);
        addVec(1, 1, 11'h4, 0, 1, 0, 11'h20, WD,            1, 0, 1, 0, 0, 1, 0, 11'h4,  0,            0, 0);
        addVec(1, 1, 11'h4, 0, 1, 0, 11'h20, WD,            0, 1, 1, 0, 0, 1, 0, 11'h20, WD,           0, 0);
        addVec(1, 1, 11'h4, 0, 1, 0, 11'h20, WD,            1, 0, 0, 1, 0, 1, 0, 11'h4,  0,            2, 32'hC000_0020);
        addVec(1, 1, 11'h4, 0, 1, 0, 11'h20, WD,            1, 0, 1, 0, 0, 1, 0, 11'h4,  0,            1, 32'hC000_0004);
        addVec(1, 1, 11'h4, 0, 1, 0, 11'h20, WD,            1, 0, 1, 0, 0, 1, 0, 11'h4,  0,            0, 0);
        addVec(1, 1, 11'h4, 0, 1, 0, 11'h20, WD,            1, 0, 1, 0, 0, 1, 0, 11'h4,  0,            0, 0);
        addVec(1, 1, 11'h4, 0, 1, 0, 11'h20, WD,            0, 1, 1, 0, 0, 1, 0, 11'h20, WD,           0, 0);
        addVec(1, 0, 11'h0, 0, 0, 0, 11'h0,  0,             0, 0, 0, 1, 0, 0, 0, 11'h0,  0,            2, 32'hC000_0020);
        addVec(1, 1, 11'h1, 1, 0, 0, 11'h0,  0,             1, 0, 0, 0, 0, 1, 0, 11'h1,  0,            0, 0);
        addVec(1, 1, 11'h2, 1, 0, 0, 11'h0,  0,             0, 0, 1, 0, 0, 0, 0, 11'h0,  0,            1, 32'h22);
        addVec(1, 1, 11'h2, 1, 0, 0, 11'h0,  0,             0, 0, 0, 0, 1, 0, 0, 11'h0,  0,            0, 0);
        addVec(1, 1, 11'h2, 1, 1, 1, 11'h10, 32'hDEADBEEF,  0, 1, 0, 0, 1, 1, 1, 11'h10, 32'hDEADBEEF, 0, 0);
        addVec(1, 1, 11'h2, 1, 1, 0, 11'h10, 0,             0, 1, 0, 0, 1, 1, 0, 11'h10, 0,            0, 0);
        addVec(1, 1, 11'h10,0, 1, 0, 11'h3,  0,             0, 1, 0, 1, 1, 1, 0, 11'h3,  0,            2, 32'hDEADBEEF);
        addVec(1, 1, 11'h10,0, 0, 0, 11'h0,  0,             1, 0, 0, 1, 0, 1, 0, 11'h10, 0,            2, 32'h44);
        addVec(1, 0, 11'h0, 0, 0, 0, 11'h0,  0,             0, 0, 1, 0, 0, 0, 0, 11'h0,  0,            1, 32'hDEADBEEF);
        addVec(1, 0, 11'h0, 0, 0, 0, 11'h0,  0,             0, 0, 0, 0, 0, 0, 0, 11'h0,  0,            0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkVec(vecs[i], i);
        end

        // Loader read granted, then reset applied before its response returns.
        applyStimulus(inVec(1, 0, 11'h0, 0, 1, 0, 11'h2));
        #1;
        checkOutput("rst_seq_ld_gnt", 100, 32'(ld_gnt), 32'd1);
        applyStimulus(inVec(0, 1, 11'h0, 0, 1, 0, 11'h2));
        #1;
        checkOutput("rst_seq_grants", 101, 32'({if_gnt, ld_gnt, mem_ena}), 32'd0);
        checkOutput("rst_seq_ld_rvalid_in", 101, 32'(ld_rvalid), 32'd0);
        applyStimulus(inVec(1, 0, 11'h0, 0, 0, 0, 11'h0));
        #1;
        checkOutput("rst_seq_ld_rvalid_after", 102, 32'(ld_rvalid), 32'd0);
        checkOutput("rst_seq_if_rvalid_after", 102, 32'(if_rvalid), 32'd0);
        checkOutput("rst_seq_locked", 102, 32'(ld_locked), 32'd0);

        // Starvation counter starts from zero after reset: four denials, then a forced grant.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(inVec(1, 1, 11'h5, 0, 1, 0, 11'h21));
            #1;
            checkOutput("starve_ld_gnt", 110 + i, 32'(ld_gnt), (i == 4) ? 32'd1 : 32'd0);
            checkOutput("starve_if_gnt", 110 + i, 32'(if_gnt), (i == 4) ? 32'd0 : 32'd1);
        end
        applyStimulus(inVec(1, 0, 11'h0, 0, 0, 0, 11'h0));
        #1;
        checkOutput("starve_ld_rvalid", 115, 32'(ld_rvalid), 32'd1);
        checkOutput("starve_ld_rdata", 115, ld_rdata, 32'hC000_0021);

        // Reset while the loader holds the port abandons the lock.
        applyStimulus(inVec(1, 0, 11'h0, 1, 0, 0, 11'h0));
        #1;
        checkOutput("lock_run_locked", 120, 32'(ld_locked), 32'd0);
        applyStimulus(inVec(1, 0, 11'h0, 1, 0, 0, 11'h0));
        #1;
        checkOutput("lock_drain_locked", 121, 32'(ld_locked), 32'd0);
        applyStimulus(inVec(1, 1, 11'h0, 1, 0, 0, 11'h0));
        #1;
        checkOutput("lock_load_locked", 122, 32'(ld_locked), 32'd1);
        checkOutput("lock_load_if_gnt", 122, 32'(if_gnt), 32'd0);
        applyStimulus(inVec(0, 1, 11'h0, 1, 1, 1, 11'h7));
        #1;
        checkOutput("lock_rst_grants", 123, 32'({if_gnt, ld_gnt, mem_ena, mem_wea}), 32'd0);
        applyStimulus(inVec(1, 1, 11'h0, 1, 0, 0, 11'h0));
        #1;
        checkOutput("lock_after_rst_locked", 124, 32'(ld_locked), 32'd0);
        checkOutput("lock_after_rst_if_gnt", 124, 32'(if_gnt), 32'd1);
        applyStimulus(inVec(1, 0, 11'h0, 0, 0, 0, 11'h0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
